// File: rtl/alu_issue_queue.sv
// alu_issue_queue: command FIFO feeding a combinational ALU plus a one-entry result register
module alu_issue_queue #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [WIDTH-1:0]           cmd_a,
  input  logic [WIDTH-1:0]           cmd_b,
  input  logic [3:0]                 cmd_sel,
  output logic [WIDTH-1:0]           A,
  output logic [WIDTH-1:0]           B,
  output logic [3:0]                 alu_sel,
  input  logic [WIDTH-1:0]           alu_out,
  input  logic                       carry_out,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [WIDTH-1:0]           res_data,
  output logic                       res_carry,
  output logic [3:0]                 res_tag,
  output logic [$clog2(DEPTH):0]     count,
  output logic [15:0]                op_count
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_a [DEPTH];
  logic [WIDTH-1:0] mem_b [DEPTH];
  logic [3:0]       mem_sel [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             push, pop, empty;
  assign empty     = count == '0;
  assign cmd_ready = !rst && (count < (AW+1)'(DEPTH));
  assign push      = cmd_valid && cmd_ready;
  assign pop       = !empty && (!res_valid || res_ready);
  assign A         = empty ? '0 : mem_a[rd_ptr];
  assign B         = empty ? '0 : mem_b[rd_ptr];
  assign alu_sel   = empty ? '0 : mem_sel[rd_ptr];
  // command storage; contents need no reset since the pointers gate visibility
  always_ff @(posedge clk) begin
    if (push) begin
      mem_a[wr_ptr]   <= cmd_a;
      mem_b[wr_ptr]   <= cmd_b;
      mem_sel[wr_ptr] <= cmd_sel;
    end
  end
  // pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= (push && !pop) ? count + 1'b1 : (!push && pop) ? count - 1'b1 : count;
    end
  end
  // result capture from the ALU, drain on handshake, delivered-result counter
  always_ff @(posedge clk) begin
    if (rst) begin
      res_valid <= 1'b0;
      res_data  <= '0;
      res_carry <= 1'b0;
      res_tag   <= '0;
      op_count  <= '0;
    end else begin
      if (pop) begin
        res_valid <= 1'b1;
        res_data  <= alu_out;
        res_carry <= carry_out;
        res_tag   <= alu_sel;
      end else if (res_ready) begin
        res_valid <= 1'b0;
      end
      op_count <= op_count + 16'(res_valid && res_ready);
    end
  end
endmodule

// File: doc/alu_issue_queue.md
# alu_issue_queue

Command buffer and result stage wrapped around the team's 8-bit combinational `alu`. It accepts operand/opcode commands through a valid/ready handshake and queues them in a DEPTH-entry FIFO. It drives the queue head onto the ALU inputs and registers `alu_out`/`carry_out` into a one-entry result holding register with its own valid/ready output handshake. It is the upstream feeder and downstream capture stage that lets the ALU sit in a streaming datapath.

## Interface
- `DEPTH`, 4: command FIFO entries; power of two, ≥2.
- `WIDTH`, 8: operand/result width; must match the ALU.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  FIFO can accept.
- `cmd_a`, `cmd_b`  in  WIDTH  operands.
- `cmd_sel`  in  4  ALU opcode.
- `A`, `B`  out  WIDTH  to ALU operands.
- `alu_sel`  out  4  to ALU opcode.
- `alu_out`  in  WIDTH  from ALU result.
- `carry_out`  in  1  from ALU carry.
- `res_valid`  out  1  result held.
- `res_ready`  in  1  consumer accepts.
- `res_data`  out  WIDTH  registered `alu_out`.
- `res_carry`  out  1  registered `carry_out`.
- `res_tag`  out  4  opcode that produced the result.
- `count`  out  log2(DEPTH)+1  FIFO occupancy.
- `op_count`  out  16  results delivered since reset.

## Operation
- Push: `cmd_valid && cmd_ready` writes {a, b, sel} at `wr_ptr`; `wr_ptr` increments modulo DEPTH.
- `cmd_ready = !rst && (count < DEPTH)`. It does not depend on a same-cycle pop, so there is no combinational path from `res_ready`.
- Show-ahead head: when `count > 0`, `A`/`B`/`alu_sel` equal the head entry. When the FIFO is empty they are 0/0/0.
- Pop condition: `count > 0 && (!res_valid || res_ready)`. On pop:
  - `res_data` ← `alu_out`, `res_carry` ← `carry_out`, `res_tag` ← head sel.
  - `res_valid` ← 1.
  - `rd_ptr` increments modulo DEPTH.
- Drain: `res_valid && res_ready` with no pop sets `res_valid` ← 0. `res_data`, `res_carry` and `res_tag` keep their last values.
- Stall: `res_valid && !res_ready` blocks pops. The result register and `A`/`B`/`alu_sel` stay stable.
- Occupancy:
  - Simultaneous push and pop leaves `count` unchanged.
  - Push only increments `count`.
  - Pop only decrements `count`.
- `op_count` increments on every `res_valid && res_ready` and wraps from 0xFFFF to 0x0000.
- Ordering is strict FIFO. No command is dropped or duplicated.

## Timing
- Reset, sampled at a rising edge, clears:
  - pointers, `count`, `res_valid`, `res_data`, `res_carry`, `res_tag` and `op_count` to 0.
  - `A`, `B` and `alu_sel` read 0.
  - `cmd_ready` is 0 while `rst` is high and 1 in the first cycle after.
- Reset mid-operation discards queued commands and any held result. Commands presented while `rst` is high are ignored.
- Latency with the block idle:
  - Command accepted at edge N.
  - Head drives the ALU during cycle N+1.
  - Result is captured at edge N+1 and `res_valid` is high in cycle N+2.
  - Total: 2 cycles from acceptance to result.
- Throughput is 1 result/cycle while `res_ready` is held high and the FIFO is non-empty.
- Full FIFO: `cmd_ready` is low the cycle after the DEPTH-th push. It returns high the cycle after the first pop.
- Empty FIFO while `res_ready` is high: `res_valid` drops after the last result is accepted.
- The ALU is purely combinational. `alu_out` is sampled in the same cycle the head is driven.

## Test plan
- **Single op:** after reset, push A=8'h05, B=8'h04, sel=4'h1.
  - `A`=05, `B`=04, `alu_sel`=1 one cycle after acceptance.
  - `res_valid` high 2 cycles after acceptance, with `res_tag`=1.
  - `res_data`/`res_carry` equal the ALU's output for (05, 04, 1).
- **Streaming:** push sel=1,2,3,4 back-to-back with A=05, B=04 and `res_ready`=1.
  - Four consecutive `res_valid` cycles with `res_tag` 1,2,3,4 in order.
  - `op_count`=4 afterwards.
- **Backpressure/full:** hold `res_ready`=0 and push DEPTH+2 commands.
  - One result is held and DEPTH commands are queued.
  - `cmd_ready` is low, `count`=DEPTH, and `res_data` plus the ALU inputs stay stable.
  - Release `res_ready`: all DEPTH+1 results arrive in order and none are lost.
- **Simultaneous push/pop:** at `count`=2 with `res_ready`=1, push in the same cycle as a pop.
  - `count` stays 2.
  - Pointers wrap correctly across at least 2×DEPTH operations.
- **Reset mid-operation:** with 3 commands queued and `res_valid`=1, assert `rst` for 1 cycle while `cmd_valid`=1.
  - Next cycle: `count`=0, `res_valid`=0, `A`=`B`=`alu_sel`=0 and `op_count`=0.
  - The command offered during reset is not queued.
- **op_count wrap:** force 65536 accepted results.
  - `op_count` returns to 0x0000.
